pwm_fade_ctrl: RTL and testbench
================================

PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

Interface
REQ-001 The block SHALL have parameter DW, default 8, giving the duty-value width that matches the PWM duty input.
REQ-002 The block SHALL have parameter TW, default 16, giving the step and hold timer width.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port req, input, 1 bit: request a new fade; sampled only in IDLE.
REQ-006 The block SHALL have port target, input, DW bits: destination duty, latched on accept.
REQ-007 The block SHALL have port loop, input, 1 bit: 1 means breathe continuously between target and 0; latched on accept.
REQ-008 The block SHALL have port step_div, input, TW bits: one LSB step occurs every step_div+1 cycles; latched on accept.
REQ-009 The block SHALL have port hold_div, input, TW bits: dwell at each loop endpoint lasts hold_div+1 cycles; latched on accept.
REQ-010 The block SHALL have port stop, input, 1 bit: abort the active fade.
REQ-011 The block SHALL have port ack, output, 1 bit: one-cycle pulse confirming that req was accepted.
REQ-012 The block SHALL have port busy, output, 1 bit: high in RAMP or HOLD.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse on non-loop arrival at target.
REQ-014 The block SHALL have port dir, output, 1 bit: 1 while ramping up, 0 otherwise.
REQ-015 The block SHALL have port pwm_data, output, DW bits: registered duty value driven to the PWM generator.

Function
REQ-016 The FSM SHALL have the states IDLE, RAMP and HOLD, and all outputs SHALL be registered.
REQ-017 In IDLE with req=1: the block SHALL latch target, loop, step_div and hold_div, set dest=target, assert ack for the next cycle only, clear the timer, and enter RAMP.
REQ-018 In RAMP and HOLD, req SHALL be ignored and ack SHALL stay 0.
REQ-019 In RAMP, arrival SHALL be checked every cycle: pwm_data==dest means arrival, and the timer SHALL clear.
REQ-020 In RAMP without arrival, the timer SHALL increment; when timer==step_div, pwm_data SHALL move 1 LSB toward dest and the timer SHALL clear; pwm_data SHALL never overshoot dest or wrap.
REQ-021 dir SHALL be 1 in RAMP when dest>pwm_data, and 0 otherwise, including in IDLE and HOLD.
REQ-022 On arrival with loop=0: done SHALL be 1 for exactly the next cycle, the FSM SHALL return to IDLE, and pwm_data SHALL hold its value.
REQ-023 On arrival with loop=1: the FSM SHALL enter HOLD; after hold_div+1 cycles, dest SHALL toggle (target becomes 0, 0 becomes the latched target) and the FSM SHALL re-enter RAMP with the timer cleared; done SHALL never assert in loop mode.
REQ-024 Timing with step_div=0: ramping from 0 to 3 SHALL give pwm_data 1, 2, 3 on the three cycles after entering RAMP, with done high one cycle after pwm_data reaches 3.
REQ-025 An accept whose target equals the current pwm_data SHALL cause arrival on the first RAMP cycle (done for loop=0, HOLD for loop=1).
REQ-026 Loop mode with latched target=0 SHALL alternate between HOLD and a single RAMP cycle with pwm_data fixed at 0.
REQ-027 stop=1 in RAMP or HOLD SHALL cause IDLE on the next cycle with pwm_data frozen, no done, and the timer cleared.
REQ-028 stop SHALL have priority over arrival or a step in the same cycle.
REQ-029 stop in IDLE SHALL have no effect; req and stop together in IDLE SHALL cause req to be accepted.
REQ-030 busy SHALL be 1 exactly while the state is RAMP or HOLD.
REQ-031 The step_div, hold_div, target and loop inputs SHALL be ignored except on the accept cycle.

Reset
REQ-032 rst=1 SHALL asynchronously force IDLE, pwm_data=0, ack=0, done=0, busy=0, dir=0, the timer to 0, and all latched configuration to 0.
REQ-033 Reset asserted mid-RAMP or mid-HOLD SHALL abandon the operation immediately; after release, the block SHALL wait for a new req.
REQ-034 The first req SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-035 The bench SHALL run: reset, then req with target=3, step_div=0, loop=0 -> ack at cycle 1, pwm_data 1/2/3 on cycles 2-4, done at cycle 5 only, busy low from cycle 5.
REQ-036 The bench SHALL run: pwm_data=3, req with target=1, step_div=2 -> pwm_data 3->2->1 with each step 3 cycles apart, dir=0 throughout, one done pulse.
REQ-037 The bench SHALL run: loop=1, target=2, step_div=0, hold_div=1 -> ramp 0 to 2, hold 2 cycles, ramp 2 to 0, hold 2 cycles, repeat for 3 periods; done never asserts.
REQ-038 The bench SHALL run: stop in the same cycle as a scheduled step mid-ramp -> IDLE next cycle, pwm_data unchanged, no done; a subsequent req is acked.
REQ-039 The bench SHALL run: req held high during RAMP -> no second ack until return to IDLE; req and stop together in IDLE -> accepted.
REQ-040 The bench SHALL run: rst pulsed asynchronously between clock edges during HOLD -> all outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/pwm_fade_ctrl.sv
// PWM duty fader: ramps a registered duty value one LSB at a time toward a
// destination, optionally breathing between the target and zero with a dwell.
module pwm_fade_ctrl #(
  parameter int DW = 8,
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic [DW-1:0] target,
  input  logic          loop,
  input  logic [TW-1:0] step_div,
  input  logic [TW-1:0] hold_div,
  input  logic          stop,
  output logic          ack,
  output logic          busy,
  output logic          done,
  output logic          dir,
  output logic [DW-1:0] pwm_data
);

  typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [TW-1:0] step_q;
  logic [TW-1:0] hold_q;
  logic [DW-1:0] tgt_q;
  logic          loop_q;
  logic [DW-1:0] dest;
  logic [DW-1:0] pwm_nxt;
  logic [DW-1:0] dest_nxt;

  // Only used when pwm_data != dest, so the one-LSB move never wraps or overshoots.
  always_comb begin
    pwm_nxt  = (dest > pwm_data) ? pwm_data + DW'(1) : pwm_data - DW'(1);
    dest_nxt = (dest != '0) ? '0 : tgt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      step_q   <= '0;
      hold_q   <= '0;
      tgt_q    <= '0;
      loop_q   <= 1'b0;
      dest     <= '0;
      pwm_data <= '0;
      ack      <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      dir      <= 1'b0;
    end else begin
      ack  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          dir <= 1'b0;
          if (req) begin
            tgt_q  <= target;
            loop_q <= loop;
            step_q <= step_div;
            hold_q <= hold_div;
            dest   <= target;
            timer  <= '0;
            ack    <= 1'b1;
            busy   <= 1'b1;
            dir    <= (target > pwm_data);
            state  <= RAMP;
          end
        end
        RAMP: begin
          if (stop) begin
            state <= IDLE;
            timer <= '0;
            busy  <= 1'b0;
            dir   <= 1'b0;
          end else if (pwm_data == dest) begin
            timer <= '0;
            dir   <= 1'b0;
            if (loop_q) begin
              state <= HOLD;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else if (timer == step_q) begin
            timer    <= '0;
            pwm_data <= pwm_nxt;
            dir      <= (dest > pwm_nxt);
          end else begin
            timer <= timer + TW'(1);
            dir   <= (dest > pwm_data);
          end
        end
        HOLD: begin
          if (stop) begin
            state <= IDLE;
            timer <= '0;
            busy  <= 1'b0;
            dir   <= 1'b0;
          end else if (timer == hold_q) begin
            dest  <= dest_nxt;
            timer <= '0;
            dir   <= (dest_nxt > pwm_data);
            state <= RAMP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          dir   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl; expected values are hand-derived per cycle
// (cycle n = 1 ns after the n-th rising edge following the accept edge).
module tb_pwm_fade_ctrl;
  localparam int DW = 8;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic [DW-1:0] target;
  logic          loop;
  logic [TW-1:0] step_div;
  logic [TW-1:0] hold_div;
  logic          stop;
  logic          ack, busy, done, dir;
  logic [DW-1:0] pwm_data;

  int checks   = 0;
  int failures = 0;

  int lp_pwm [10] = '{0, 1, 2, 2, 2, 2, 1, 0, 0, 0};
  int lp_dir [10] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
  int dn_pwm [8]  = '{3, 3, 3, 2, 2, 2, 1, 1};
  int rq_ack [4]  = '{1, 0, 0, 1};

  pwm_fade_ctrl #(.DW(DW), .TW(TW)) dut (
    .clk(clk), .rst(rst), .req(req), .target(target), .loop(loop),
    .step_div(step_div), .hold_div(hold_div), .stop(stop),
    .ack(ack), .busy(busy), .done(done), .dir(dir), .pwm_data(pwm_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int t, input int lp, input int sd, input int hd);
    req      = 1'b1;
    target   = DW'(t);
    loop     = lp[0];
    step_div = TW'(sd);
    hold_div = TW'(hd);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; target = '0; loop = 1'b0;
    step_div = '0; hold_div = '0; stop = 1'b0;
    step(); step();
    chk("rst_pwm", pwm_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_done", done, 0);
    chk("rst_dir", dir, 0);

    // Up-ramp 0->3, step_div=0; req is driven in the same cycle rst drops.
    rst = 1'b0;
    launch(3, 0, 0, 0);
    step();
    req = 1'b0;
    chk("up_ack_c1", ack, 1);
    chk("up_busy_c1", busy, 1);
    chk("up_dir_c1", dir, 1);
    chk("up_pwm_c1", pwm_data, 0);
    for (int c = 2; c <= 4; c++) begin
      step();
      chk($sformatf("up_pwm_c%0d", c), pwm_data, c - 1);
      chk($sformatf("up_done_c%0d", c), done, 0);
      chk($sformatf("up_ack_c%0d", c), ack, 0);
    end
    step();
    chk("up_done_c5", done, 1);
    chk("up_busy_c5", busy, 0);
    chk("up_pwm_c5", pwm_data, 3);
    step();
    chk("up_done_c6", done, 0);

    // Down-ramp 3->1 with step_div=2: steps three cycles apart.
    launch(1, 0, 2, 0);
    for (int c = 1; c <= 9; c++) begin
      step();
      req = 1'b0;
      if (c <= 8) chk($sformatf("dn_pwm_c%0d", c), pwm_data, dn_pwm[c-1]);
      chk($sformatf("dn_dir_c%0d", c), dir, 0);
      chk($sformatf("dn_done_c%0d", c), done, (c == 8) ? 1 : 0);
    end

    // Return to 0 before the breathing run.
    launch(0, 0, 0, 0);
    step(); req = 1'b0;
    step();
    chk("z_pwm", pwm_data, 0);
    step();
    chk("z_done", done, 1);

    // Breathing 0<->2, hold 2 cycles, three 10-cycle periods, then stop in HOLD.
    launch(2, 1, 0, 1);
    for (int c = 1; c <= 30; c++) begin
      step();
      req = 1'b0;
      chk($sformatf("lp_pwm_c%0d", c), pwm_data, lp_pwm[(c-1)%10]);
      chk($sformatf("lp_dir_c%0d", c), dir, lp_dir[(c-1)%10]);
      chk($sformatf("lp_busy_c%0d", c), busy, 1);
      chk($sformatf("lp_done_c%0d", c), done, 0);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("lp_stop_busy", busy, 0);
    chk("lp_stop_pwm", pwm_data, 0);
    chk("lp_stop_done", done, 0);

    // Stop on the same cycle a step is due (step_div=1, step due at c4).
    launch(5, 0, 1, 0);
    step(); req = 1'b0;
    chk("st_ack", ack, 1);
    step(); step();
    chk("st_pwm_c3", pwm_data, 1);
    step();
    chk("st_pwm_c4", pwm_data, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("st_busy_c5", busy, 0);
    chk("st_pwm_c5", pwm_data, 1);
    chk("st_done_c5", done, 0);
    chk("st_dir_c5", dir, 0);
    step();
    chk("st_done_c6", done, 0);
    chk("st_pwm_c6", pwm_data, 1);

    // req held high: second accept only after returning to IDLE (target==pwm then).
    launch(2, 0, 0, 0);
    for (int c = 1; c <= 4; c++) begin
      step();
      chk($sformatf("rh_ack_c%0d", c), ack, rq_ack[c-1]);
    end
    req = 1'b0;
    step();
    chk("rh_done_c5", done, 1);
    chk("rh_busy_c5", busy, 0);
    chk("rh_pwm_c5", pwm_data, 2);

    // req and stop together in IDLE: accepted.
    launch(2, 0, 0, 0);
    stop = 1'b1;
    step();
    req = 1'b0; stop = 1'b0;
    chk("rs_ack", ack, 1);
    chk("rs_busy", busy, 1);
    step();
    chk("rs_done", done, 1);

    // Async reset between edges while in HOLD.
    launch(2, 1, 0, 3);
    step(); req = 1'b0;
    step(); step();
    chk("ar_busy_pre", busy, 1);
    chk("ar_pwm_pre", pwm_data, 2);
    #2 rst = 1'b1;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_pwm", pwm_data, 0);
    chk("ar_ack", ack, 0);
    chk("ar_done", done, 0);
    chk("ar_dir", dir, 0);
    #1 rst = 1'b0;
    step(); step();
    chk("ar_idle_busy", busy, 0);
    chk("ar_idle_pwm", pwm_data, 0);

    // Loop with target 0: alternates HOLD / single RAMP, pwm pinned at 0.
    launch(0, 1, 0, 0);
    for (int c = 1; c <= 6; c++) begin
      step();
      req = 1'b0;
      chk($sformatf("l0_pwm_c%0d", c), pwm_data, 0);
      chk($sformatf("l0_busy_c%0d", c), busy, 1);
      chk($sformatf("l0_done_c%0d", c), done, 0);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("l0_stop_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
